// File: rtl/updn_counter.sv
// Run-time configurable up/down counter: wrap, saturate, one-shot and ping-pong modes.
// Optional prescaler enabled by defining UPDN_PRESCALE_EN (adds the i_psc port).
module updn_counter #(
    parameter int WIDTH     = 4,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic                 i_dir,
    input  logic [1:0]           i_mode,
    input  logic [WIDTH-1:0]     i_lo,
    input  logic [WIDTH-1:0]     i_hi,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_ldval,
`ifdef UPDN_PRESCALE_EN
    input  logic [PSC_WIDTH-1:0] i_psc,
`endif
    output logic [WIDTH-1:0]     o_cnt,
    output logic                 o_tc,
    output logic                 o_done,
    output logic                 o_dir,
    output logic                 o_cfg_err
);

    typedef enum logic [1:0] {
        M_WRAP    = 2'd0,
        M_SAT     = 2'd1,
        M_ONESHOT = 2'd2,
        M_PING    = 2'd3
    } mode_e;

    mode_e            w_mode;
    logic             w_tick;
    logic             w_step;
    logic             w_sdir;
    logic [WIDTH-1:0] w_start;
    logic [WIDTH-1:0] w_end;
    logic [WIDTH-1:0] w_clamp;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_dir_nxt;
    logic             w_done_nxt;
    logic             w_tc_nxt;

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_done;
    logic             r_dir;

    assign w_mode    = mode_e'(i_mode);
    assign o_cfg_err = (i_lo > i_hi);

`ifdef UPDN_PRESCALE_EN
    logic [PSC_WIDTH-1:0] r_psc;

    // ">=" rather than "==" so lowering i_psc mid-count never forces a full wrap
    assign w_tick = (r_psc >= i_psc);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)               r_psc <= '0;
        else if (i_clr || i_load)  r_psc <= '0;
        else if (i_en)             r_psc <= w_tick ? '0 : r_psc + PSC_WIDTH'(1);
    end
`else
    // Without a prescaler every enabled cycle is a tick
    assign w_tick = (PSC_WIDTH > 0);
`endif

    assign w_step = i_en && w_tick && !o_cfg_err && !(w_mode == M_ONESHOT && r_done);
    assign w_sdir = (w_mode == M_PING) ? r_dir : i_dir;

    always_comb begin
        w_start    = w_sdir ? i_hi : i_lo;
        w_end      = w_sdir ? i_lo : i_hi;
        // Clamp against lo first so hi wins when the bounds are inverted
        w_clamp    = (i_ldval < i_lo) ? i_lo : i_ldval;
        w_clamp    = (w_clamp > i_hi) ? i_hi : w_clamp;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = w_sdir;
        w_done_nxt = r_done;
        w_tc_nxt   = 1'b0;
        if (i_clr) begin
            w_cnt_nxt  = i_dir ? i_hi : i_lo;
            w_dir_nxt  = i_dir;
            w_done_nxt = 1'b0;
        end else if (i_load) begin
            w_cnt_nxt  = w_clamp;
            w_dir_nxt  = i_dir;
            w_done_nxt = 1'b0;
        end else if (w_step) begin
            if (r_cnt < i_lo || r_cnt > i_hi) begin
                w_cnt_nxt = w_start;
            end else if (r_cnt == w_end) begin
                w_tc_nxt = 1'b1;
                case (w_mode)
                    M_WRAP:    w_cnt_nxt = w_start;
                    M_SAT:     w_cnt_nxt = r_cnt;
                    M_ONESHOT: w_done_nxt = 1'b1;
                    M_PING: begin
                        w_dir_nxt = ~w_sdir;
                        if (i_lo != i_hi)
                            w_cnt_nxt = w_sdir ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
                    end
                    default:   w_cnt_nxt = r_cnt;
                endcase
            end else begin
                w_cnt_nxt = w_sdir ? r_cnt - WIDTH'(1) : r_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt  <= '0;
            r_tc   <= 1'b0;
            r_done <= 1'b0;
            r_dir  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tc   <= w_tc_nxt;
            r_done <= w_done_nxt;
            r_dir  <= w_dir_nxt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tc   = r_tc;
    assign o_done = r_done;
    assign o_dir  = r_dir;

endmodule

// File: tb/tb_updn_counter.sv
// Self-checking bench for updn_counter: directed vector table, hand sequences and
// randomized stimulus against a behavioural model. Define UPDN_PRESCALE_EN for the prescaler.
module tb_updn_counter;
    localparam int W = 4;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_en = 1'b0, i_dir = 1'b0, i_clr = 1'b0, i_load = 1'b0;
    logic [1:0]   i_mode = 2'd0;
    logic [W-1:0] i_lo = '0, i_hi = 4'd15, i_ldval = '0;
    logic [W-1:0] o_cnt;
    logic         o_tc, o_done, o_dir, o_cfg_err;
`ifdef UPDN_PRESCALE_EN
    logic [7:0]   i_psc = 8'd0;
`endif

    updn_counter #(.WIDTH(W), .PSC_WIDTH(8)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_dir(i_dir), .i_mode(i_mode),
        .i_lo(i_lo), .i_hi(i_hi), .i_clr(i_clr), .i_load(i_load), .i_ldval(i_ldval),
`ifdef UPDN_PRESCALE_EN
        .i_psc(i_psc),
`endif
        .o_cnt(o_cnt), .o_tc(o_tc), .o_done(o_done), .o_dir(o_dir), .o_cfg_err(o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int m_cnt = 0, m_tc = 0, m_done = 0, m_dir = 0, m_psc = 0;

    typedef struct {
        logic clr, load, en, dir;
        logic [1:0] mode;
        logic [W-1:0] lo, hi, ldval;
        int cnt, tc, done, dir_o, err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: next state computed from the counting rules with integer arithmetic
    task automatic model_step();
        int lo, hi, v, sd, nd;
        bit err, tick;
        lo = int'(i_lo);
        hi = int'(i_hi);
        err = lo > hi;
        m_tc = 0;
        if (i_clr) begin
            m_cnt = i_dir ? hi : lo; m_dir = int'(i_dir); m_done = 0; m_psc = 0;
            return;
        end
        if (i_load) begin
            v = int'(i_ldval);
            v = (v < lo) ? lo : v;
            v = (v > hi) ? hi : v;
            m_cnt = v; m_dir = int'(i_dir); m_done = 0; m_psc = 0;
            return;
        end
        tick = 1'b1;
`ifdef UPDN_PRESCALE_EN
        if (i_en) begin
            if (m_psc >= int'(i_psc)) m_psc = 0;
            else begin m_psc++; tick = 1'b0; end
        end
`endif
        if (i_mode != 2'd3) m_dir = int'(i_dir);
        sd = m_dir;
        if (!i_en || !tick || err || (i_mode == 2'd2 && m_done == 1)) return;
        if (m_cnt < lo || m_cnt > hi) begin
            m_cnt = (sd != 0) ? hi : lo;
        end else if (m_cnt == ((sd != 0) ? lo : hi)) begin
            m_tc = 1;
            case (i_mode)
                2'd0: m_cnt = (sd != 0) ? hi : lo;
                2'd2: m_done = 1;
                2'd3: begin
                    nd = (sd != 0) ? 0 : 1;
                    if (lo != hi) m_cnt = (sd != 0) ? lo + 1 : hi - 1;
                    m_dir = nd;
                end
                default: ;
            endcase
        end else begin
            m_cnt = m_cnt + ((sd != 0) ? -1 : 1);
        end
    endtask

    task automatic clk_step();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".cnt"}, int'(o_cnt), m_cnt);
        chk({tag, ".tc"}, int'(o_tc), m_tc);
        chk({tag, ".done"}, int'(o_done), m_done);
        chk({tag, ".dir"}, int'(o_dir), m_dir);
        chk({tag, ".err"}, int'(o_cfg_err), (i_lo > i_hi) ? 1 : 0);
    endtask

    initial begin
        // clr load en dir mode lo hi ldval | cnt tc done dir err
        tbl.push_back('{0,1,0,1,1,3,9,5,    5,0,0,1,0});
        tbl.push_back('{0,0,1,1,1,3,9,0,    4,0,0,1,0});
        tbl.push_back('{0,0,1,1,1,3,9,0,    3,0,0,1,0});
        tbl.push_back('{0,0,1,1,1,3,9,0,    3,1,0,1,0});
        tbl.push_back('{0,0,1,1,1,3,9,0,    3,1,0,1,0});
        tbl.push_back('{0,0,0,1,1,3,9,0,    3,0,0,1,0});
        tbl.push_back('{1,0,0,0,2,2,5,0,    2,0,0,0,0});
        tbl.push_back('{0,0,1,0,2,2,5,0,    3,0,0,0,0});
        tbl.push_back('{0,0,1,0,2,2,5,0,    4,0,0,0,0});
        tbl.push_back('{0,0,1,0,2,2,5,0,    5,0,0,0,0});
        tbl.push_back('{0,0,1,0,2,2,5,0,    5,1,1,0,0});
        tbl.push_back('{0,0,1,0,2,2,5,0,    5,0,1,0,0});
        tbl.push_back('{0,0,1,0,2,2,5,0,    5,0,1,0,0});
        tbl.push_back('{1,0,1,0,2,2,5,0,    2,0,0,0,0});
        tbl.push_back('{1,0,0,0,3,1,4,0,    1,0,0,0,0});
        tbl.push_back('{0,0,1,1,3,1,4,0,    2,0,0,0,0});
        tbl.push_back('{0,0,1,0,3,1,4,0,    3,0,0,0,0});
        tbl.push_back('{0,0,1,0,3,1,4,0,    4,0,0,0,0});
        tbl.push_back('{0,0,1,0,3,1,4,0,    3,1,0,1,0});
        tbl.push_back('{0,0,1,0,3,1,4,0,    2,0,0,1,0});
        tbl.push_back('{0,0,1,0,3,1,4,0,    1,0,0,1,0});
        tbl.push_back('{0,0,1,0,3,1,4,0,    2,1,0,0,0});
        tbl.push_back('{0,0,1,0,3,7,7,0,    7,0,0,0,0});
        tbl.push_back('{0,0,1,0,3,7,7,0,    7,1,0,1,0});
        tbl.push_back('{0,0,1,0,3,7,7,0,    7,1,0,0,0});
        tbl.push_back('{0,0,1,0,3,7,7,0,    7,1,0,1,0});
        tbl.push_back('{1,1,1,1,0,3,9,12,   9,0,0,1,0});
        tbl.push_back('{0,1,1,0,0,3,9,12,   9,0,0,0,0});
        tbl.push_back('{0,0,1,0,0,3,9,0,    3,1,0,0,0});
        tbl.push_back('{0,1,0,0,0,3,9,6,    6,0,0,0,0});
        tbl.push_back('{0,0,1,0,0,8,3,0,    6,0,0,0,1});
        tbl.push_back('{0,0,1,0,0,8,3,0,    6,0,0,0,1});
        tbl.push_back('{0,1,1,0,0,8,3,1,    3,0,0,0,1});
        tbl.push_back('{1,0,1,1,0,8,3,0,    3,0,0,1,1});
        tbl.push_back('{0,0,1,0,0,0,15,0,   4,0,0,0,0});

        // Reset state
        #3;
        chk("rst.cnt", int'(o_cnt), 0);
        chk("rst.tc", int'(o_tc), 0);
        chk("rst.done", int'(o_done), 0);
        chk("rst.dir", int'(o_dir), 0);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;

        // Free-running wrap over the full range
        i_en = 1'b1; i_dir = 1'b0; i_mode = 2'd0; i_lo = 4'd0; i_hi = 4'd15;
        for (int k = 1; k <= 20; k++) begin
            clk_step();
            chk("wrap.cnt", int'(o_cnt), k % 16);
            chk("wrap.tc", int'(o_tc), (k == 16) ? 1 : 0);
        end

        for (int n = 0; n < tbl.size(); n++) begin
            i_clr = tbl[n].clr; i_load = tbl[n].load; i_en = tbl[n].en; i_dir = tbl[n].dir;
            i_mode = tbl[n].mode; i_lo = tbl[n].lo; i_hi = tbl[n].hi; i_ldval = tbl[n].ldval;
            clk_step();
            chk($sformatf("vec%0d.cnt", n), int'(o_cnt), tbl[n].cnt);
            chk($sformatf("vec%0d.tc", n), int'(o_tc), tbl[n].tc);
            chk($sformatf("vec%0d.done", n), int'(o_done), tbl[n].done);
            chk($sformatf("vec%0d.dir", n), int'(o_dir), tbl[n].dir_o);
            chk($sformatf("vec%0d.err", n), int'(o_cfg_err), tbl[n].err);
        end
        i_clr = 1'b0; i_load = 1'b0;

        // Asynchronous reset in the middle of a count
        i_en = 1'b1; i_dir = 1'b1; i_mode = 2'd0; i_lo = 4'd2; i_hi = 4'd12;
        repeat (3) clk_step();
        #2 i_rstn = 1'b0;
        #1;
        chk("arst.cnt", int'(o_cnt), 0);
        chk("arst.tc", int'(o_tc), 0);
        chk("arst.done", int'(o_done), 0);
        chk("arst.dir", int'(o_dir), 0);
        m_cnt = 0; m_tc = 0; m_done = 0; m_dir = 0; m_psc = 0;
        #2 i_rstn = 1'b1;
        clk_step();
        chk_model("arst_rel");

`ifdef UPDN_PRESCALE_EN
        // Divide-by-3 with an enable gap: phase must survive the gap
        i_psc = 8'd2; i_mode = 2'd0; i_dir = 1'b0; i_lo = 4'd0; i_hi = 4'd15;
        i_en = 1'b0; i_clr = 1'b1;
        clk_step();
        i_clr = 1'b0; i_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clk_step();
            chk("psc.run", int'(o_cnt), (k >= 2) ? 1 : 0);
        end
        i_en = 1'b0;
        repeat (5) begin
            clk_step();
            chk("psc.hold", int'(o_cnt), 1);
        end
        i_en = 1'b1;
        clk_step();
        chk("psc.resume1", int'(o_cnt), 1);
        clk_step();
        chk("psc.resume2", int'(o_cnt), 2);
`endif

        // Randomized stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            int a, b;
            i_clr  = ($urandom_range(0, 39) == 0);
            i_load = ($urandom_range(0, 39) == 0);
            i_en   = ($urandom_range(0, 4) != 0);
            i_ldval = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) i_dir = ~i_dir;
            if ($urandom_range(0, 15) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                if ($urandom_range(0, 7) == 0) begin
                    i_lo = W'((a > b) ? a : b); i_hi = W'((a > b) ? b : a);
                end else begin
                    i_lo = W'((a > b) ? b : a); i_hi = W'((a > b) ? a : b);
                end
            end
`ifdef UPDN_PRESCALE_EN
            if ($urandom_range(0, 63) == 0) i_psc = 8'($urandom_range(0, 3));
`endif
            clk_step();
            chk_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
